button_command_scheduler: RTL
=============================

# button_command_scheduler

Converts the 4-button debounced level vector from the button debouncer into discrete tester commands and issues them to the serial-flash test sequencer over a valid/ready handshake. It distinguishes short and long presses, holds each command until accepted, and tracks completion with a timeout. While a command is outstanding, it locks out further presses. It sits between the debouncer output and the command input of the test sequencer.

## Interface
- FCLK, 20000000, system clock frequency in Hz
- HOLD_MS, 1000, long-press threshold in ms; c_hold = FCLK*HOLD_MS/1000 cycles, computed in 64-bit and fitting 32 bits
- TIMEOUT_MS, 5000, completion timeout in ms; c_to = FCLK*TIMEOUT_MS/1000 cycles
- i_clk_mhz  in  1  system clock; single clock domain
- i_rstn_mhz  in  1  reset, synchronous, active-low
- i_btns_deb  in  4  debounced button levels; at most one bit set
- o_cmd_valid  out  1  command request
- o_cmd_code  out  3  {long, idx[1:0]}; idx = index of pressed bit (bit0→0 … bit3→3)
- i_cmd_ready  in  1  sequencer accepts the command
- i_op_done  in  1  single-cycle completion pulse from the sequencer
- o_busy  out  1  high in ST_ISSUE and ST_WAIT
- o_timeout  out  1  single-cycle pulse when completion does not arrive in time
- o_last_cmd  out  3  last accepted command code

## Operation
- States: ST_IDLE, ST_PRESS, ST_ISSUE, ST_WAIT, ST_REL.
- Counter s_t is 32 bits. It is cleared on every state change and increments in ST_PRESS and ST_WAIT.
- ST_IDLE:
  - If i_btns_deb != 0: latch idx, then go to ST_PRESS.
  - If the vector has more than one bit set: ignore it and stay in ST_IDLE.
- ST_PRESS, priority order:
  - (1) i_btns_deb == 0: ST_ISSUE, code {0, idx} (short press).
  - (2) i_btns_deb != latched one-hot: ST_REL, no command.
  - (3) s_t == c_hold-1: ST_ISSUE, code {1, idx} (long press).
  - (4) Otherwise stay.
- ST_ISSUE:
  - o_cmd_valid = 1 and o_cmd_code is held stable.
  - On i_cmd_ready = 1: o_last_cmd <= code, then ST_WAIT.
  - There is no abandon path. A command, once raised, stays raised until accepted.
- ST_WAIT:
  - i_op_done = 1: ST_REL.
  - Otherwise, if s_t == c_to-1: pulse o_timeout, then ST_REL.
  - i_op_done takes priority over timeout in the same cycle.
- ST_REL:
  - i_btns_deb == 0: ST_IDLE. Otherwise stay.
  - This re-arms the block only after a full release, so a held long press cannot retrigger.
- Presses during ST_ISSUE, ST_WAIT and ST_REL are ignored, never queued.
- i_op_done outside ST_WAIT is ignored.

## Timing
- Reset (i_rstn_mhz = 0 at a rising edge):
  - State goes to ST_IDLE and s_t to 0.
  - o_cmd_valid, o_cmd_code, o_busy, o_timeout and o_last_cmd all go to 0.
  - Reset mid-handshake drops o_cmd_valid the next cycle without an accept.
- All outputs are registered or are decoded only from registered state. There is no combinational input-to-output path.
- Press latency: press sampled at edge N gives ST_PRESS from N+1.
- Short press: release sampled in ST_PRESS at edge M gives o_cmd_valid = 1 from M+1.
- Long press:
  - o_cmd_valid rises exactly c_hold+1 cycles after the press edge N.
  - A release in the same cycle as s_t == c_hold-1 yields a short press.
- Handshake:
  - Transfer occurs on the edge where o_cmd_valid & i_cmd_ready.
  - o_cmd_valid falls the following cycle.
  - o_last_cmd updates on the transfer edge.
  - i_cmd_ready already high when valid rises gives a 1-cycle valid.
- Timeout: o_timeout is high for exactly one cycle, c_to cycles after the transfer edge.
- Back-to-back: the minimum spacing between two commands is transfer → done → ST_REL → ST_IDLE → ST_PRESS, with release gating.

## Test plan
All scenarios use FCLK = 20000, HOLD_MS = 5 (c_hold = 100) and TIMEOUT_MS = 10 (c_to = 200).

- **Reset:** hold i_rstn_mhz = 0 for 3 cycles with i_btns_deb = 4'b0100 → all outputs 0 and state ST_IDLE after release.
- **Short press:**
  - Stimulus: i_btns_deb = 4'b0010 for 20 cycles then 0; i_cmd_ready = 1; i_op_done pulsed 10 cycles later.
  - Response: one valid cycle with code 3'b001, o_last_cmd = 3'b001, o_busy high until done, no timeout.
- **Long press with delayed ready:**
  - Stimulus: 4'b1000 held 300 cycles; i_cmd_ready asserted 5 cycles after valid.
  - Response: valid rises 101 cycles after the press edge and is held 5 cycles with code 3'b111. No second command while still held. Re-arm only after release.
- **Boundary release:** release on the exact cycle s_t == 99 → code 3'b000 for button 0 (short, not long).
- **Timeout:** command accepted, no i_op_done → o_timeout pulses once exactly 200 cycles after transfer; o_busy falls the next cycle. A done pulse on that cycle instead suppresses the timeout.
- **Lockout / glitch:**
  - Presses during ST_WAIT produce no command.
  - 4'b0001 changing to 4'b0100 mid-press produces no command; the block waits for all-zero before accepting a new press.

Source files
------------

// File: rtl/button_command_scheduler_if.sv
// Command handshake between the button scheduler (master) and the
// serial-flash test sequencer (slave).
interface button_command_scheduler_if;
  logic       o_cmd_valid;
  logic [2:0] o_cmd_code;
  logic       i_cmd_ready;
  logic       i_op_done;

  modport master (
    output o_cmd_valid,
    output o_cmd_code,
    input  i_cmd_ready,
    input  i_op_done
  );

  modport slave (
    input  o_cmd_valid,
    input  o_cmd_code,
    output i_cmd_ready,
    output i_op_done
  );
endinterface

// File: rtl/button_command_scheduler.sv
// Turns a debounced one-hot button vector into short/long press commands,
// holds each command until the sequencer accepts it, then waits for the
// completion pulse (or a timeout) and for a full release before re-arming.
module button_command_scheduler #(
  parameter int unsigned FCLK       = 20000000,
  parameter int unsigned HOLD_MS    = 1000,
  parameter int unsigned TIMEOUT_MS = 5000
) (
  input  logic                               i_clk_mhz,
  input  logic                               i_rstn_mhz,
  input  logic [3:0]                         i_btns_deb,
  button_command_scheduler_if.master         cmd,
  output logic                               o_busy,
  output logic                               o_timeout,
  output logic [2:0]                         o_last_cmd
);

  // Thresholds are computed in 64 bits so FCLK*MS cannot overflow.
  localparam logic [63:0] C_HOLD64 = 64'(FCLK) * 64'(HOLD_MS) / 64'd1000;
  localparam logic [63:0] C_TO64   = 64'(FCLK) * 64'(TIMEOUT_MS) / 64'd1000;
  localparam logic [31:0] C_HOLD_M1 = C_HOLD64[31:0] - 32'd1;
  localparam logic [31:0] C_TO_M1   = C_TO64[31:0] - 32'd1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRESS = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_REL   = 3'd4
  } state_t;

  state_t      state_q;
  logic [31:0] t_q;
  logic [1:0]  idx_q;
  logic [2:0]  code_q;
  logic        valid_q;
  logic        busy_q;
  logic        timeout_q;
  logic [2:0]  last_q;

  logic [1:0]  idx_d;
  logic        onehot_d;
  logic [3:0]  sel_d;

  // Decode the pressed button index and reject multi-bit vectors.
  always_comb begin
    idx_d    = 2'd0;
    onehot_d = 1'b0;
    case (i_btns_deb)
      4'b0001: begin idx_d = 2'd0; onehot_d = 1'b1; end
      4'b0010: begin idx_d = 2'd1; onehot_d = 1'b1; end
      4'b0100: begin idx_d = 2'd2; onehot_d = 1'b1; end
      4'b1000: begin idx_d = 2'd3; onehot_d = 1'b1; end
      default: begin idx_d = 2'd0; onehot_d = 1'b0; end
    endcase
    sel_d = 4'b0001 << idx_q;
  end

  // Scheduler FSM; all outputs are registered alongside the state.
  always_ff @(posedge i_clk_mhz) begin
    if (!i_rstn_mhz) begin
      state_q   <= ST_IDLE;
      t_q       <= 32'd0;
      idx_q     <= 2'd0;
      code_q    <= 3'd0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      last_q    <= 3'd0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (onehot_d) begin
            idx_q   <= idx_d;
            t_q     <= 32'd0;
            state_q <= ST_PRESS;
          end
        end
        ST_PRESS: begin
          if (i_btns_deb == 4'd0) begin
            // Release wins over the hold threshold in the same cycle.
            code_q  <= {1'b0, idx_q};
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            t_q     <= 32'd0;
            state_q <= ST_ISSUE;
          end else if (i_btns_deb != sel_d) begin
            // Button changed mid-press: drop it and wait for full release.
            t_q     <= 32'd0;
            state_q <= ST_REL;
          end else if (t_q == C_HOLD_M1) begin
            code_q  <= {1'b1, idx_q};
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            t_q     <= 32'd0;
            state_q <= ST_ISSUE;
          end else begin
            t_q <= t_q + 32'd1;
          end
        end
        ST_ISSUE: begin
          // No abandon path: the command stays up until accepted.
          if (cmd.i_cmd_ready) begin
            last_q  <= code_q;
            valid_q <= 1'b0;
            t_q     <= 32'd0;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cmd.i_op_done) begin
            busy_q  <= 1'b0;
            t_q     <= 32'd0;
            state_q <= ST_REL;
          end else if (t_q == C_TO_M1) begin
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            t_q       <= 32'd0;
            state_q   <= ST_REL;
          end else begin
            t_q <= t_q + 32'd1;
          end
        end
        ST_REL: begin
          // Re-arm only after everything is released, so a held button
          // cannot retrigger.
          if (i_btns_deb == 4'd0) begin
            t_q     <= 32'd0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          t_q     <= 32'd0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd.o_cmd_valid = valid_q;
  assign cmd.o_cmd_code  = code_q;
  assign o_busy          = busy_q;
  assign o_timeout       = timeout_q;
  assign o_last_cmd      = last_q;

endmodule
